// File: rtl/cmp_pkg.sv
// cmp_pkg: shared encodings and default widths for the comparator statistics block
package cmp_pkg;
   localparam int N  = 4;
   localparam int CW = 8;
   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_GT   = 2'd1;
   localparam logic [1:0] RES_EQ   = 2'd2;
   localparam logic [1:0] RES_LT   = 2'd3;
   typedef enum logic {ST_ACCUM, ST_DUMP} st_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating counter exposing its next value so a snapshot can include the current update
module sat_counter #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          zero,
   input  logic          one,
   input  logic          inc,
   output logic [CW-1:0] q,
   output logic [CW-1:0] nxt
);
   always_comb nxt = zero ? '0 : one ? CW'(1) : (inc && q != '1) ? q + 1'b1 : q;
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else     q <= clr ? '0 : nxt;
endmodule

// File: rtl/cmp_stream_stats.sv
// cmp_stream_stats: re-checks comparator flags and emits per-frame result statistics
module cmp_stream_stats #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [N-1:0]  in_b,
   input  logic          in_y2,
   input  logic          in_y1,
   input  logic          in_y0,
   input  logic          frame_end,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] gt_cnt,
   output logic [CW-1:0] eq_cnt,
   output logic [CW-1:0] lt_cnt,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] max_run
);
   import cmp_pkg::*;
   st_t st, st_n;
   logic acc, fin, good;
   logic [2:0] ref_f;
   logic [1:0] res, last_res;
   logic [CW-1:0] gt_q, eq_q, lt_q, err_q, run_q, max_acc;
   logic [CW-1:0] gt_n, eq_n, lt_n, err_n, run_n, max_n;
   always_comb begin
      st_n      = st;
      in_ready  = st == ST_ACCUM;
      out_valid = st == ST_DUMP;
      if (st == ST_ACCUM && in_valid && frame_end) st_n = ST_DUMP;
      if (st == ST_DUMP && out_ready) st_n = ST_ACCUM;
   end
   always_comb begin
      acc   = in_valid & in_ready;
      fin   = acc & frame_end;
      ref_f = {in_a > in_b, in_a == in_b, in_a < in_b};
      good  = {in_y2, in_y1, in_y0} == ref_f;
      res   = ref_f[2] ? RES_GT : ref_f[1] ? RES_EQ : RES_LT;
      max_n = run_n > max_acc ? run_n : max_acc;
   end
   sat_counter #(.CW(CW)) u_gt (.clk(clk), .rst(rst), .clr(fin), .zero(1'b0), .one(1'b0),
      .inc(acc & good & (res == RES_GT)), .q(gt_q), .nxt(gt_n));
   sat_counter #(.CW(CW)) u_eq (.clk(clk), .rst(rst), .clr(fin), .zero(1'b0), .one(1'b0),
      .inc(acc & good & (res == RES_EQ)), .q(eq_q), .nxt(eq_n));
   sat_counter #(.CW(CW)) u_lt (.clk(clk), .rst(rst), .clr(fin), .zero(1'b0), .one(1'b0),
      .inc(acc & good & (res == RES_LT)), .q(lt_q), .nxt(lt_n));
   sat_counter #(.CW(CW)) u_err (.clk(clk), .rst(rst), .clr(fin), .zero(1'b0), .one(1'b0),
      .inc(acc & ~good), .q(err_q), .nxt(err_n));
   // Run length: a bad beat breaks the run, a new result restarts it at one
   sat_counter #(.CW(CW)) u_run (.clk(clk), .rst(rst), .clr(fin), .zero(acc & ~good),
      .one(acc & good & (res != last_res)), .inc(acc & good & (res == last_res)),
      .q(run_q), .nxt(run_n));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st       <= ST_ACCUM;
         last_res <= RES_NONE;
         max_acc  <= '0;
         gt_cnt   <= '0;
         eq_cnt   <= '0;
         lt_cnt   <= '0;
         err_cnt  <= '0;
         max_run  <= '0;
      end else begin
         st       <= st_n;
         last_res <= fin ? RES_NONE : acc ? (good ? res : RES_NONE) : last_res;
         max_acc  <= fin ? '0 : max_n;
         if (fin) begin
            gt_cnt  <= gt_n;
            eq_cnt  <= eq_n;
            lt_cnt  <= lt_n;
            err_cnt <= err_n;
            max_run <= max_n;
         end
      end
endmodule

// File: tb/tb_cmp_stream_stats.sv
// tb_cmp_stream_stats: randomized frames checked every cycle against a frame-level reference model
module tb_cmp_stream_stats;
   typedef struct {logic [3:0] a; logic [3:0] b; logic [2:0] f;} beat_t;
   typedef struct {int gt; int eq; int lt; int err; int mx;} rec_t;
   logic clk = 0, rst = 1, in_valid = 0, in_ready, frame_end = 0, out_valid, out_ready = 1;
   logic in_y2 = 0, in_y1 = 0, in_y0 = 0;
   logic [3:0] in_a = 0, in_b = 0;
   logic [7:0] gt_cnt, eq_cnt, lt_cnt, err_cnt, max_run;
   int total = 0, bad = 0, acc_cnt = 0, or_mode = 1;
   bit exp_dump = 0, started = 0;
   beat_t bq[$];
   rec_t exp_rec = '{0, 0, 0, 0, 0};

   cmp_stream_stats #(.N(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_y2(in_y2), .in_y1(in_y1), .in_y0(in_y0), .frame_end(frame_end), .out_valid(out_valid),
      .out_ready(out_ready), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
      .max_run(max_run));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
      end
   endtask

   function automatic int sat(input int v);
      return v > 255 ? 255 : v;
   endfunction

   // Whole-frame reference: classify each beat, count, and scan for the longest good run
   function automatic rec_t calc(input beat_t q[$]);
      rec_t r = '{0, 0, 0, 0, 0};
      int run = 0, last = -1, res;
      foreach (q[i]) begin
         if (q[i].f == {q[i].a > q[i].b, q[i].a == q[i].b, q[i].a < q[i].b}) begin
            res = q[i].a > q[i].b ? 0 : q[i].a == q[i].b ? 1 : 2;
            if (res == 0) r.gt++;
            else if (res == 1) r.eq++;
            else r.lt++;
            run = res == last ? sat(run + 1) : 1;
            last = res;
         end else begin
            r.err++;
            run = 0;
            last = -1;
         end
         if (run > r.mx) r.mx = run;
      end
      r.gt = sat(r.gt); r.eq = sat(r.eq); r.lt = sat(r.lt); r.err = sat(r.err);
      return r;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         bq.delete();
         exp_dump = 0;
      end else if (!exp_dump && in_valid) begin
         bq.push_back('{in_a, in_b, {in_y2, in_y1, in_y0}});
         acc_cnt++;
         if (frame_end) begin
            exp_rec = calc(bq);
            bq.delete();
            exp_dump = 1;
         end
      end else if (exp_dump && out_ready) exp_dump = 0;
   end

   initial forever begin
      @(negedge clk);
      if (started && !rst) begin
         chk("in_ready", in_ready, !exp_dump);
         chk("out_valid", out_valid, exp_dump);
         if (exp_dump) begin
            chk("gt_cnt", gt_cnt, exp_rec.gt);
            chk("eq_cnt", eq_cnt, exp_rec.eq);
            chk("lt_cnt", lt_cnt, exp_rec.lt);
            chk("err_cnt", err_cnt, exp_rec.err);
            chk("max_run", max_run, exp_rec.mx);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      out_ready = or_mode == 2 ? 1'($urandom_range(0, 1)) : or_mode[0];
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f, input logic fe);
      int n = acc_cnt, k = 0;
      in_valid = 1; in_a = a; in_b = b; {in_y2, in_y1, in_y0} = f; frame_end = fe;
      while (acc_cnt == n && k < 500) begin
         cyc();
         k++;
      end
      if (acc_cnt == n) chk("accept_timeout", 0, 1);
      in_valid = 0;
      frame_end = 0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (exp_dump && k < 500) begin
         cyc();
         k++;
      end
      if (exp_dump) chk("drain_timeout", 0, 1);
   endtask

   task automatic rnd_beat(input logic fe);
      logic [3:0] a = 4'($urandom), b = 4'($urandom);
      logic [2:0] f = $urandom_range(0, 3) == 0 ? 3'($urandom) : {a > b, a == b, a < b};
      beat(a, b, f, fe);
   endtask

   task automatic lit(input int g, input int e, input int l, input int r, input int m);
      chk("model_gt", exp_rec.gt, g);   chk("dut_gt", gt_cnt, g);
      chk("model_eq", exp_rec.eq, e);   chk("dut_eq", eq_cnt, e);
      chk("model_lt", exp_rec.lt, l);   chk("dut_lt", lt_cnt, l);
      chk("model_err", exp_rec.err, r); chk("dut_err", err_cnt, r);
      chk("model_max", exp_rec.mx, m);  chk("dut_max", max_run, m);
      chk("lit_valid", out_valid, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_gt", gt_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_max", max_run, 0);
      #1 rst = 0;
      started = 1;
      cyc();
      beat(4'b1000, 4'b1010, 3'b001, 0);
      beat(4'b0100, 4'b1011, 3'b001, 0);
      beat(4'b1111, 4'b1100, 3'b100, 0);
      beat(4'b0011, 4'b1111, 3'b001, 0);
      beat(4'b0111, 4'b0111, 3'b010, 1);
      lit(1, 1, 3, 0, 2);
      wait_idle();
      beat(4'b1111, 4'b1100, 3'b110, 0);
      beat(4'b0111, 4'b0111, 3'b000, 0);
      beat(4'b0011, 4'b1111, 3'b001, 1);
      lit(0, 0, 1, 2, 1);
      wait_idle();
      or_mode = 0;
      beat(4'b0001, 4'b0000, 3'b100, 1);
      in_valid = 1; in_a = 4'b0010; in_b = 4'b0101; {in_y2, in_y1, in_y0} = 3'b001;
      repeat (10) cyc();
      chk("bp_hold_acc", acc_cnt, 6 + 3 + 1 - 1);
      or_mode = 1;
      beat(4'b0010, 4'b0101, 3'b001, 1);
      lit(0, 0, 1, 0, 1);
      for (int i = 0; i < 300; i++) beat(4'b0001, 4'b0000, 3'b100, i == 299);
      lit(255, 0, 0, 0, 255);
      wait_idle();
      for (int i = 0; i < 3; i++) rnd_beat(0);
      rst = 1;
      cyc();
      rst = 0;
      beat(4'b0111, 4'b0111, 3'b010, 1);
      lit(0, 1, 0, 0, 1);
      wait_idle();
      or_mode = 0;
      rnd_beat(1);
      repeat (2) cyc();
      rst = 1;
      cyc();
      rst = 0;
      or_mode = 1;
      cyc();
      for (int i = 0; i < 20; i++) rnd_beat(1);
      or_mode = 2;
      for (int fr = 0; fr < 30; fr++) begin
         int len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) rnd_beat(i == len - 1);
      end
      or_mode = 1;
      wait_idle();
      repeat (2) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
